// File: rtl/fft1024_pkg.sv
// Shared constants and packed complex type for the 1024-point FFT datapath.
package fft1024_pkg;

    localparam int unsigned FFT_N    = 1024;
    localparam int unsigned FFT_M    = 10;
    localparam int unsigned TW_W     = 16;
    localparam int unsigned TW_SCALE = 32767;
    localparam real         TW_PI    = 3.14159265358979323846;

    typedef struct packed {
        logic signed [TW_W-1:0] re;
        logic signed [TW_W-1:0] im;
    } cplx_t;

    function automatic cplx_t cplx_pack(input logic signed [TW_W-1:0] re,
                                        input logic signed [TW_W-1:0] im);
        cplx_t c;
        c.re = re;
        c.im = im;
        return c;
    endfunction

endpackage

// File: rtl/fft1024_qcos_rom.sv
// Quarter-wave cosine table C(m) = round(SCALE*cos(2*pi*m/N)), m = 0..N/4, two read ports.
module fft1024_qcos_rom
    import fft1024_pkg::*;
(
    input  logic [8:0]      addr_a,
    input  logic [8:0]      addr_b,
    output logic [TW_W-1:0] cos_a,
    output logic [TW_W-1:0] cos_b
);

    localparam int unsigned DEPTH = FFT_N / 4 + 1;

    logic [TW_W-1:0] table_w [512];

    // Contents are fixed at elaboration; int'() of a real rounds half away from zero.
    for (genvar m = 0; m < 512; m++) begin : g_tab
        if (m < DEPTH) begin : g_val
            localparam real ANG = 2.0 * TW_PI * real'(m) / real'(FFT_N);
            assign table_w[m] = TW_W'(int'(real'(TW_SCALE) * $cos(ANG)));
        end else begin : g_pad
            assign table_w[m] = '0;
        end
    end

    always_comb begin
        cos_a = table_w[addr_a];
        cos_b = table_w[addr_b];
    end

endmodule

// File: rtl/fft1024_twiddle_rom.sv
// Twiddle ROM W_N^n = {re, im} in signed Q1.15, quadrant-folded from a quarter cosine table.
module fft1024_twiddle_rom
    import fft1024_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset,
    input  logic [FFT_M-1:0]  n,
    output logic [2*TW_W-1:0] twiddle
);

    logic [1:0]             quad;
    logic [7:0]             rem;
    logic [8:0]             addr_fwd;
    logic [8:0]             addr_rev;
    logic [TW_W-1:0]        cos_fwd;
    logic [TW_W-1:0]        cos_rev;
    logic signed [TW_W-1:0] c_f;
    logic signed [TW_W-1:0] c_r;
    cplx_t                  twiddle_d;
    cplx_t                  twiddle_q;

    assign quad     = n[FFT_M-1:FFT_M-2];
    assign rem      = n[FFT_M-3:0];
    assign addr_fwd = {1'b0, rem};
    // r = 0 must reach index 256, hence the 9-bit complement.
    assign addr_rev = 9'd256 - {1'b0, rem};

    fft1024_qcos_rom u_qcos (
        .addr_a (addr_fwd),
        .addr_b (addr_rev),
        .cos_a  (cos_fwd),
        .cos_b  (cos_rev)
    );

    assign c_f = signed'(cos_fwd);
    assign c_r = signed'(cos_rev);

    always_comb begin
        twiddle_d = '0;
        unique case (quad)
            2'd0:    twiddle_d = cplx_pack( c_f, -c_r);
            2'd1:    twiddle_d = cplx_pack(-c_r, -c_f);
            2'd2:    twiddle_d = cplx_pack(-c_f,  c_r);
            default: twiddle_d = cplx_pack( c_r,  c_f);
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            twiddle_q <= '0;
        end else begin
            twiddle_q <= twiddle_d;
        end
    end

    assign twiddle = twiddle_q;

endmodule

// File: tb/tb_fft1024_twiddle_rom.sv
// Self-checking bench for fft1024_twiddle_rom against a full-angle real-valued twiddle model.
module tb_fft1024_twiddle_rom;

    logic        Clk;
    logic        Reset;
    logic [9:0]  n;
    logic [31:0] twiddle;

    int unsigned vectors = 0;
    int unsigned errs    = 0;

    fft1024_twiddle_rom dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .n       (n),
        .twiddle (twiddle)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic int round_away(input real v);
        if (v >= 0.0) return int'($floor(v + 0.5));
        return -int'($floor(-v + 0.5));
    endfunction

    function automatic logic [31:0] golden(input int unsigned idx);
        real ang;
        int  ir;
        int  ii;
        logic [31:0] w;
        ang = 2.0 * 3.14159265358979323846 * real'(idx) / 1024.0;
        ir  = round_away(32767.0 * $cos(ang));
        ii  = round_away(-32767.0 * $sin(ang));
        w   = {ir[15:0], ii[15:0]};
        return w;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_range(input string tag, input logic [31:0] obs);
        vectors++;
        assert (obs[31:16] !== 16'h8000 && obs[15:0] !== 16'h8000) else begin
            errs++;
            $error("FAIL %s: observed %h contains -32768", tag, obs);
        end
    endtask

    task automatic step(input int unsigned idx, input string tag);
        @(negedge Clk);
        n = 10'(idx);
        @(posedge Clk);
        #1;
        check(tag, twiddle, golden(idx));
    endtask

    task automatic step_const(input int unsigned idx, input logic [31:0] exp, input string tag);
        @(negedge Clk);
        n = 10'(idx);
        @(posedge Clk);
        #1;
        check(tag, twiddle, exp);
    endtask

    initial begin
        Reset = 1'b0;
        n     = 10'd5;
        #1;
        check("reset_initial", twiddle, 32'h0000_0000);

        @(negedge Clk);
        Reset = 1'b1;
        n     = 10'd1;
        @(posedge Clk);
        #1;
        check("first_after_reset", twiddle, 32'h7FFE_FF37);

        step_const(0,   32'h7FFF_0000, "axis_0");
        step_const(256, 32'h0000_8001, "axis_256");
        step_const(512, 32'h8001_0000, "axis_512");
        step_const(768, 32'h0000_7FFF, "axis_768");
        step_const(128, 32'h5A82_A57E, "octant_128");
        step_const(384, 32'hA57E_A57E, "octant_384");
        step_const(1023, 32'h7FFE_00C9, "wrap_1023");

        // Async clear between edges, then held across an edge.
        step_const(0, 32'h7FFF_0000, "pre_async");
        Reset = 1'b0;
        #1;
        check("async_clear", twiddle, 32'h0000_0000);
        n = 10'd128;
        @(posedge Clk);
        #1;
        check("reset_hold", twiddle, 32'h0000_0000);
        @(negedge Clk);
        Reset = 1'b1;

        // Latency: output follows n sampled at the previous edge, not the live input.
        step(0, "lat_0");
        @(negedge Clk);
        n = 10'd256;
        #1;
        check("lat_hold_0", twiddle, golden(0));
        @(posedge Clk);
        #1;
        check("lat_256", twiddle, golden(256));
        @(negedge Clk);
        n = 10'd512;
        #1;
        check("lat_hold_256", twiddle, golden(256));
        @(posedge Clk);
        #1;
        check("lat_512", twiddle, golden(512));

        for (int unsigned i = 0; i < 1024; i++) begin
            step(i, "sweep");
            check_range("sweep_range", twiddle);
            if (i == 600) begin
                Reset = 1'b0;
                #1;
                check("mid_clear", twiddle, 32'h0000_0000);
                @(posedge Clk);
                #1;
                check("mid_hold", twiddle, 32'h0000_0000);
                @(negedge Clk);
                Reset = 1'b1;
            end
        end

        for (int unsigned k = 0; k < 200; k++) begin
            step($urandom_range(0, 1023), "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
